store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 118 +++++++++++
 tb/tb_store_buffer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and a single-ported data memory.
// Word stores are queued in a FIFO and drained whenever the memory port is
// not claimed by a load. Loads read through the buffer: the youngest resident
// entry with a matching word address forwards its data, otherwise the memory
// read data is returned. A full buffer forces a drain ahead of any load.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_ready,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    output logic        ld_ready,
    output logic [31:0] ld_data,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    output logic        empty,
    output logic [4:0]  count
);

    localparam int         PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    // Entry payload only; occupancy is tracked by head/tail/count, so these
    // arrays never need clearing.
    logic [29:0] addr_q [DEPTH];
    logic [31:0] data_q [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    logic             full;
    logic             st_acc;
    logic             ld_grant;
    logic             drain;
    logic             fwd_hit;
    logic [31:0]      fwd_data;
    logic [PTR_W-1:0] idx;

    // Byte-offset bits of store addresses are deliberately dropped.
    logic unused_st_lsb;
    assign unused_st_lsb = ^st_addr[1:0];

    // Occupancy flags come from registered count only, so st_ready never
    // depends on this cycle's drain (a slot freed now is usable next cycle).
    assign full     = (count == DEPTH_C);
    assign empty    = (count == 5'd0);
    assign st_ready = !full;
    assign st_acc   = st_valid && !full;

    // A load owns the port unless the buffer is full; otherwise drain if
    // anything is buffered. Async reset clears count, which drops dm_we at once.
    assign ld_grant = ld_valid && !full;
    assign ld_ready = ld_grant;
    assign drain    = !ld_grant && !empty;
    assign dm_we    = drain;

    // Memory port address/data mux: load address, head entry, or idle zeros.
    always_comb begin
        dm_addr  = 32'd0;
        dm_wdata = 32'd0;
        if (ld_grant) begin
            dm_addr = ld_addr;
        end else if (drain) begin
            dm_addr  = {addr_q[head], 2'b00};
            dm_wdata = data_q[head];
        end
    end

    // Forwarding search from oldest to youngest so the youngest match wins;
    // the head entry stays visible even while it is being drained.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = 32'd0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((5'(i) < count) && (addr_q[idx] == ld_addr[31:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end

    assign ld_data = (ld_valid && fwd_hit) ? fwd_data : dm_rdata;

    // FIFO control: pointers and occupancy, cleared asynchronously.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head  <= '0;
            tail  <= '0;
            count <= 5'd0;
        end else begin
            if (st_acc) begin
                tail <= tail + PTR_W'(1);
            end
            if (drain) begin
                head <= head + PTR_W'(1);
            end
            count <= count + 5'(st_acc) - 5'(drain);
        end
    end

    // Entry payload capture at the tail slot.
    always_ff @(posedge clk) begin
        if (st_acc) begin
            addr_q[tail] <= st_addr[31:2];
            data_q[tail] <= st_data;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_ready;
    logic [31:0] ld_data;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        empty;
    logic [4:0]  count;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .st_valid (st_valid),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .st_ready (st_ready),
        .ld_valid (ld_valid),
        .ld_addr  (ld_addr),
        .ld_ready (ld_ready),
        .ld_data  (ld_data),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .empty    (empty),
        .count    (count)
    );

    // Reference model: program-ordered list of buffered stores.
    typedef struct {
        logic [29:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic exp_drain;
    logic exp_acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                         input logic lv, input logic [31:0] la);
        @(negedge clk);
        st_valid = sv;
        st_addr  = sa;
        st_data  = sd;
        ld_valid = lv;
        ld_addr  = la;
        dm_rdata = $urandom;
        #1;
    endtask

    // Predict every output from the model and compare.
    task automatic expect_all(input string tag);
        int          n;
        logic        e_full;
        logic        own;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_ld;
        n         = q.size();
        e_full    = (n == DEPTH);
        own       = ld_valid && !e_full;
        exp_drain = !own && (n > 0);
        exp_acc   = st_valid && !e_full;
        e_addr    = 32'd0;
        e_wdata   = 32'd0;
        if (own) begin
            e_addr = ld_addr;
        end else if (exp_drain) begin
            e_addr  = {q[0].a, 2'b00};
            e_wdata = q[0].d;
        end
        e_ld = dm_rdata;
        if (ld_valid) begin
            for (int i = 0; i < n; i++) begin
                if (q[i].a == ld_addr[31:2]) e_ld = q[i].d;
            end
        end
        check({tag, ".st_ready"}, st_ready, !e_full);
        check({tag, ".ld_ready"}, ld_ready, own);
        check({tag, ".dm_we"},    dm_we,    exp_drain);
        check({tag, ".dm_addr"},  dm_addr,  e_addr);
        check({tag, ".dm_wdata"}, dm_wdata, e_wdata);
        check({tag, ".ld_data"},  ld_data,  e_ld);
        check({tag, ".empty"},    empty,    (n == 0));
        check({tag, ".count"},    count,    n);
    endtask

    task automatic commit();
        @(posedge clk);
        if (exp_drain) void'(q.pop_front());
        if (exp_acc) q.push_back('{st_addr[31:2], st_data});
    endtask

    task automatic step(input string tag, input logic sv, input logic [31:0] sa,
                        input logic [31:0] sd, input logic lv, input logic [31:0] la);
        drive(sv, sa, sd, lv, la);
        expect_all(tag);
        commit();
    endtask

    task automatic drain_all(input string tag);
        int guard;
        guard = 0;
        while (q.size() != 0 && guard < 20) begin
            step(tag, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
            guard++;
        end
        check({tag, ".drain_bound"}, (q.size() == 0), 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int guard;
        int ld_pct;
        logic        sv;
        logic        lv;
        logic [31:0] sa;
        logic [31:0] la;

        rstn     = 1'b0;
        st_valid = 1'b0;
        st_addr  = 32'd0;
        st_data  = 32'd0;
        ld_valid = 1'b1;
        ld_addr  = 32'h0000_1234;
        dm_rdata = 32'hCAFE_0001;
        #3;
        check("rst.st_ready", st_ready, 1'b1);
        check("rst.empty",    empty,    1'b1);
        check("rst.count",    count,    5'd0);
        check("rst.dm_we",    dm_we,    1'b0);
        check("rst.ld_ready", ld_ready, 1'b1);
        check("rst.ld_data",  ld_data,  32'hCAFE_0001);
        @(posedge clk);
        #1 rstn = 1'b1;

        // Single store drains the following cycle.
        step("s036a", 1'b1, 32'h100, 32'h1111_1111, 1'b0, 32'd0);
        drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        check("s036.dm_we",    dm_we,    1'b1);
        check("s036.dm_addr",  dm_addr,  32'h100);
        check("s036.dm_wdata", dm_wdata, 32'h1111_1111);
        expect_all("s036b");
        commit();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        check("s036.empty", empty, 1'b1);
        expect_all("s036c");
        commit();

        // Two stores to one word, load forwards the younger, drains keep order.
        step("s037a", 1'b1, 32'h200, 32'hA, 1'b1, 32'h800);
        step("s037b", 1'b1, 32'h200, 32'hB, 1'b1, 32'h800);
        drive(1'b0, 32'd0, 32'd0, 1'b1, 32'h203);
        check("s037.ld_data",  ld_data,  32'hB);
        check("s037.ld_ready", ld_ready, 1'b1);
        check("s037.dm_we",    dm_we,    1'b0);
        expect_all("s037c");
        commit();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        check("s037.w1_addr", dm_addr,  32'h200);
        check("s037.w1_data", dm_wdata, 32'hA);
        expect_all("s037d");
        commit();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        check("s037.w2_data", dm_wdata, 32'hB);
        expect_all("s037e");
        commit();
        drain_all("s037f");

        // Five stores with a non-matching load held: fill, forced drain, retry.
        k = 0;
        guard = 0;
        while (k < 5 && guard < 20) begin
            drive(1'b1, 32'h400 + 32'(k * 4), 32'(k + 1), 1'b1, 32'hF00);
            if (q.size() == DEPTH) begin
                check("s038.st_ready_full", st_ready, 1'b0);
                check("s038.ld_ready_full", ld_ready, 1'b0);
                check("s038.dm_we_full",    dm_we,    1'b1);
                check("s038.count_full",    count,    5'd4);
            end
            expect_all("s038");
            commit();
            if (exp_acc) k++;
            guard++;
        end
        check("s038.bound", (k == 5), 1'b1);
        drain_all("s038z");

        // Same-cycle store and load to one word on an empty buffer.
        drive(1'b1, 32'h300, 32'h5, 1'b1, 32'h300);
        check("s039.ld_data", ld_data, dm_rdata);
        expect_all("s039a");
        commit();
        drive(1'b0, 32'd0, 32'd0, 1'b1, 32'h900);
        check("s039.count", count, 5'd1);
        expect_all("s039b");
        commit();
        drain_all("s039c");

        // Async reset in the middle of a drain with three entries buffered.
        for (int i = 0; i < 3; i++) begin
            step("s041a", 1'b1, 32'h500 + 32'(i * 4), 32'h50 + 32'(i), 1'b1, 32'hA00);
        end
        drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        check("s041.count_pre", count, 5'd3);
        check("s041.we_pre",    dm_we, 1'b1);
        #2 rstn = 1'b0;
        #1;
        check("s041.we_rst",    dm_we,    1'b0);
        check("s041.count_rst", count,    5'd0);
        check("s041.empty_rst", empty,    1'b1);
        check("s041.ready_rst", st_ready, 1'b1);
        q.delete();
        @(posedge clk);
        #1 rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("s041b", 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        end

        // Randomized traffic with phases of light to heavy load pressure.
        for (int c = 0; c < 3000; c++) begin
            ld_pct = (((c / 150) % 3) == 0) ? 20 : ((((c / 150) % 3) == 1) ? 60 : 95);
            sv = ($urandom_range(0, 99) < 60);
            lv = ($urandom_range(0, 99) < ld_pct);
            sa = 32'h200 + (32'($urandom_range(0, 5)) << 2) + 32'($urandom_range(0, 3));
            la = 32'h200 + (32'($urandom_range(0, 5)) << 2) + 32'($urandom_range(0, 3));
            step("rnd", sv, sa, $urandom, lv, la);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
